mem_arbiter: RTL and testbench

Sequencing controller for the single shared main memory that sits behind the instruction and data caches. It accepts block-fill requests from the I-cache and D-cache and single-word write-through requests from the D-cache. It grants one requester at a time, issues eight pipelined word reads per fill to a fixed-latency memory, and returns each word tagged with its index.

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/fill_counter.sv | 62 ++++++
 rtl/mem_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the main-memory arbiter.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    ST_HOLDOFF,
    ST_IDLE,
    ST_FILL_I,
    ST_FILL_D,
    ST_WRITE
  } state_t;

  localparam int BLOCK_WORDS = 8;
  localparam int WORD_IDX_W  = 3;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/fill_counter.sv
// Word counters for one block fill (issue side and return side), 8th-return
// detection, and the post-reset holdoff down-counter that lets stale memory
// returns drain before any grant.
module fill_counter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic                  i_active,
  input  logic                  i_holdoff,
  input  logic                  i_data_valid,
  output logic                  o_issue,
  output logic [WORD_IDX_W-1:0] o_issue_idx,
  output logic [WORD_IDX_W-1:0] o_ret_idx,
  output logic                  o_done,
  output logic                  o_hold_zero
);

  localparam logic [2:0]            HOLD_INIT = 3'(MEM_LATENCY - 1);
  localparam logic [WORD_IDX_W-1:0] LAST_WORD = WORD_IDX_W'(BLOCK_WORDS - 1);

  logic [WORD_IDX_W:0]   r_issue_cnt;
  logic [WORD_IDX_W-1:0] r_ret_cnt;
  logic [2:0]            r_hold_cnt;

  // Issue counter: cleared at grant, advances once per fill cycle until all 8 are out.
  always_ff @(posedge clk) begin
    if (rst || i_start) begin
      r_issue_cnt <= '0;
    end else if (i_active && !r_issue_cnt[WORD_IDX_W]) begin
      r_issue_cnt <= r_issue_cnt + 4'd1;
    end
  end

  // Return counter: cleared at grant, advances on each accepted read return.
  always_ff @(posedge clk) begin
    if (rst || i_start) begin
      r_ret_cnt <= '0;
    end else if (i_active && i_data_valid) begin
      r_ret_cnt <= r_ret_cnt + 3'd1;
    end
  end

  // Holdoff counter: reloaded by reset, counts down only while holding off.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold_cnt <= HOLD_INIT;
    end else if (i_holdoff && (r_hold_cnt != 3'd0)) begin
      r_hold_cnt <= r_hold_cnt - 3'd1;
    end
  end

  assign o_issue     = i_active && !r_issue_cnt[WORD_IDX_W];
  assign o_issue_idx = r_issue_cnt[WORD_IDX_W-1:0];
  assign o_ret_idx   = r_ret_cnt;
  assign o_done      = i_active && i_data_valid && (r_ret_cnt == LAST_WORD);
  assign o_hold_zero = (r_hold_cnt == 3'd0);

endmodule

// File: rtl/mem_arbiter.sv
// Shared main-memory sequencer for the I-cache and D-cache. Grants one
// requester at a time: a single-cycle write-through, or an 8-word pipelined
// block fill from a fixed-latency memory with each returned word tagged.
// Build option: define MEM_ARB_RR_EN to make the I-miss/D-miss choice
// round-robin (a pending write still wins); otherwise write > D miss > I miss.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_miss_req,
  input  logic [15:0]           i_miss_addr,
  input  logic                  d_miss_req,
  input  logic [15:0]           d_miss_addr,
  input  logic                  d_wr_req,
  input  logic [15:0]           d_wr_addr,
  input  logic [15:0]           d_wr_data,
  output logic                  i_fill_valid,
  output logic                  d_fill_valid,
  output logic [WORD_IDX_W-1:0] fill_word,
  output logic [15:0]           fill_data,
  output logic                  i_fill_done,
  output logic                  d_fill_done,
  output logic                  d_wr_ack,
  output logic                  mem_en,
  output logic                  mem_wr,
  output logic [15:0]           mem_addr,
  output logic [15:0]           mem_wdata,
  input  logic [15:0]           mem_rdata,
  input  logic                  mem_data_valid,
  output logic                  busy
);

  state_t                r_state;
  state_t                w_next;
  logic [15:0]           r_addr;
  logic [15:0]           r_wdata;
  logic                  r_busy;
  logic                  w_grant_wr;
  logic                  w_grant_d;
  logic                  w_grant_i;
  logic                  w_pick_d;
  logic                  w_fill;
  logic                  w_issue;
  logic                  w_done;
  logic                  w_hold_zero;
  logic                  w_rv;
  logic [WORD_IDX_W-1:0] w_issue_idx;
  logic [WORD_IDX_W-1:0] w_ret_idx;

`ifdef MEM_ARB_RR_EN
  logic r_last;

  // Remember which miss port was served last so a tie goes to the other one.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= PORT_I;
    end else if (w_grant_d) begin
      r_last <= PORT_D;
    end else if (w_grant_i) begin
      r_last <= PORT_I;
    end
  end

  assign w_pick_d = d_miss_req && (!i_miss_req || (r_last == PORT_I));
`else
  assign w_pick_d = d_miss_req;
`endif

  assign w_fill = (r_state == ST_FILL_I) || (r_state == ST_FILL_D);

  fill_counter #(
    .MEM_LATENCY (MEM_LATENCY)
  ) u_cnt (
    .clk          (clk),
    .rst          (rst),
    .i_start      (w_grant_d || w_grant_i),
    .i_active     (w_fill),
    .i_holdoff    (r_state == ST_HOLDOFF),
    .i_data_valid (mem_data_valid),
    .o_issue      (w_issue),
    .o_issue_idx  (w_issue_idx),
    .o_ret_idx    (w_ret_idx),
    .o_done       (w_done),
    .o_hold_zero  (w_hold_zero)
  );

  // Next-state and grant decode; arbitration only happens in IDLE.
  always_comb begin
    w_next     = r_state;
    w_grant_wr = 1'b0;
    w_grant_d  = 1'b0;
    w_grant_i  = 1'b0;
    case (r_state)
      ST_HOLDOFF: if (w_hold_zero) w_next = ST_IDLE;
      ST_IDLE: begin
        if (d_wr_req) begin
          w_grant_wr = 1'b1;
          w_next     = ST_WRITE;
        end else if (w_pick_d) begin
          w_grant_d = 1'b1;
          w_next    = ST_FILL_D;
        end else if (i_miss_req) begin
          w_grant_i = 1'b1;
          w_next    = ST_FILL_I;
        end
      end
      ST_FILL_I, ST_FILL_D: if (w_done) w_next = ST_IDLE;
      ST_WRITE: w_next = ST_IDLE;
      default: w_next = ST_HOLDOFF;
    endcase
  end

  // State register; busy is registered so it reads 0 in the cycle right after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_HOLDOFF;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != ST_IDLE);
    end
  end

  // Capture the granted address/data so memory outputs never depend on live inputs.
  always_ff @(posedge clk) begin
    if (w_grant_wr) begin
      r_addr  <= d_wr_addr & 16'hFFFE;
      r_wdata <= d_wr_data;
    end else if (w_grant_d) begin
      r_addr <= d_miss_addr & 16'hFFF0;
    end else if (w_grant_i) begin
      r_addr <= i_miss_addr & 16'hFFF0;
    end
  end

  assign w_rv = w_fill && mem_data_valid;

  // Output decode from registered state/counters; fill outputs forward memory returns.
  always_comb begin
    mem_en       = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = 16'h0000;
    mem_wdata    = 16'h0000;
    d_wr_ack     = 1'b0;
    i_fill_valid = (r_state == ST_FILL_I) && mem_data_valid;
    d_fill_valid = (r_state == ST_FILL_D) && mem_data_valid;
    i_fill_done  = (r_state == ST_FILL_I) && w_done;
    d_fill_done  = (r_state == ST_FILL_D) && w_done;
    fill_word    = w_rv ? w_ret_idx : '0;
    fill_data    = w_rv ? mem_rdata : 16'h0000;
    busy         = r_busy;
    if (w_issue) begin
      mem_en   = 1'b1;
      mem_addr = {r_addr[15:4], w_issue_idx, 1'b0};
    end else if (r_state == ST_WRITE) begin
      mem_en    = 1'b1;
      mem_wr    = 1'b1;
      mem_addr  = r_addr;
      mem_wdata = r_wdata;
      d_wr_ack  = 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios with literal
// expectations, then randomized requesters checked every cycle against a
// transaction-level timing model. Honours MEM_ARB_RR_EN like the design.
module tb_mem_arbiter;
  localparam int L = 4;
  localparam int M_HOLD = 0, M_IDLE = 1, M_FILL = 2, M_WRITE = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_miss_req = 1'b0, d_miss_req = 1'b0, d_wr_req = 1'b0;
  logic [15:0] i_miss_addr = '0, d_miss_addr = '0, d_wr_addr = '0, d_wr_data = '0;
  logic        i_fill_valid, d_fill_valid, i_fill_done, d_fill_done, d_wr_ack;
  logic [2:0]  fill_word;
  logic [15:0] fill_data, mem_addr, mem_wdata;
  logic        mem_en, mem_wr, busy;
  logic [15:0] mem_rdata = '0;
  logic        mem_data_valid = 1'b0;

  mem_arbiter #(.MEM_LATENCY(L)) dut (
    .clk(clk), .rst(rst),
    .i_miss_req(i_miss_req), .i_miss_addr(i_miss_addr),
    .d_miss_req(d_miss_req), .d_miss_addr(d_miss_addr),
    .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
    .i_fill_valid(i_fill_valid), .d_fill_valid(d_fill_valid),
    .fill_word(fill_word), .fill_data(fill_data),
    .i_fill_done(i_fill_done), .d_fill_done(d_fill_done), .d_wr_ack(d_wr_ack),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_data_valid(mem_data_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [15:0] memf(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'hC35A;
  endfunction

  // ---------------- transaction-level model ----------------
  int          md = M_HOLD, start = 0, hold_end = 0;
  bit          armed = 0, jr = 0, port_d = 0, last_d = 0;
  logic [15:0] base = '0, wa = '0, wd = '0;
  bit          s_idone = 0, s_ddone = 0, s_ack = 0;

  always @(posedge clk) begin
    bit d_fav;
    cyc = cyc + 1;
`ifdef MEM_ARB_RR_EN
    d_fav = !last_d;
`else
    d_fav = 1'b1;
`endif
    if (rst) begin
      armed = 1; md = M_HOLD; hold_end = cyc + L; jr = 1; last_d = 0;
    end else begin
      jr = 0;
      case (md)
        M_HOLD: if (cyc >= hold_end) md = M_IDLE;
        M_IDLE: begin
          if (d_wr_req) begin
            md = M_WRITE; wa = d_wr_addr & 16'hFFFE; wd = d_wr_data;
          end else if (d_miss_req && (!i_miss_req || d_fav)) begin
            md = M_FILL; port_d = 1; base = d_miss_addr & 16'hFFF0; start = cyc; last_d = 1;
          end else if (i_miss_req) begin
            md = M_FILL; port_d = 0; base = i_miss_addr & 16'hFFF0; start = cyc; last_d = 0;
          end
        end
        M_WRITE: md = M_IDLE;
        default: if (cyc == start + 8 + L) md = M_IDLE;
      endcase
    end
  end

  // ---------------- fixed-latency memory ----------------
  bit          sv [16];
  logic [15:0] sd [16];

  always @(negedge clk) begin
    if (mem_en === 1'b1 && mem_wr === 1'b0) begin
      sv[(cyc + L) % 16] = 1'b1;
      sd[(cyc + L) % 16] = memf(mem_addr);
    end
  end

  initial begin
    for (int i = 0; i < 16; i++) sv[i] = 0;
    forever begin
      @(posedge clk);
      #1;
      if (sv[cyc % 16]) begin
        mem_data_valid = 1'b1; mem_rdata = sd[cyc % 16]; sv[cyc % 16] = 0;
      end else if (armed && md != M_FILL && $urandom_range(0, 3) == 0) begin
        mem_data_valid = 1'b1; mem_rdata = 16'($urandom);
      end else begin
        mem_data_valid = 1'b0; mem_rdata = 16'($urandom);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic        e_en, e_wr, e_iv, e_dv, e_id, e_dd, e_ack, e_busy;
    logic [15:0] e_addr, e_wdata, e_data;
    logic [2:0]  e_word;
    int k, r;
    if (armed) begin
      e_en = 0; e_wr = 0; e_iv = 0; e_dv = 0; e_id = 0; e_dd = 0; e_ack = 0;
      e_addr = 0; e_wdata = 0; e_data = 0; e_word = 0;
      e_busy = (md != M_IDLE) && !jr;
      if (md == M_FILL) begin
        k = cyc - start;
        r = k - L;
        if (k < 8) begin e_en = 1; e_addr = base + 16'(2 * k); end
        if (r >= 0 && r < 8) begin
          e_iv = !port_d; e_dv = port_d; e_word = 3'(r);
          e_data = memf(base + 16'(2 * r));
          e_id = !port_d && (r == 7); e_dd = port_d && (r == 7);
        end
      end else if (md == M_WRITE) begin
        e_en = 1; e_wr = 1; e_addr = wa; e_wdata = wd; e_ack = 1;
      end
      chk("mem_en", {15'b0, mem_en}, {15'b0, e_en});
      chk("mem_wr", {15'b0, mem_wr}, {15'b0, e_wr});
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_wdata", mem_wdata, e_wdata);
      chk("i_fill_valid", {15'b0, i_fill_valid}, {15'b0, e_iv});
      chk("d_fill_valid", {15'b0, d_fill_valid}, {15'b0, e_dv});
      chk("fill_word", {13'b0, fill_word}, {13'b0, e_word});
      chk("fill_data", fill_data, e_data);
      chk("i_fill_done", {15'b0, i_fill_done}, {15'b0, e_id});
      chk("d_fill_done", {15'b0, d_fill_done}, {15'b0, e_dd});
      chk("d_wr_ack", {15'b0, d_wr_ack}, {15'b0, e_ack});
      chk("busy", {15'b0, busy}, {15'b0, e_busy});
      s_idone = e_id; s_ddone = e_dd; s_ack = e_ack;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic run_random(input int ncyc, input int p_raise, input int p_wr);
    bit i_wait = 0;
    for (int n = 0; n < ncyc; n++) begin
      tick();
      if (rst) begin
        rst = 0;
      end else if ($urandom_range(0, 399) == 0) begin
        rst = 1; i_miss_req = 0; d_miss_req = 0; d_wr_req = 0; i_wait = 0;
      end else begin
        if (i_miss_req) begin
          if (s_idone) i_miss_req = 0;
          else if (md == M_FILL && !port_d && cyc == start + 2 && $urandom_range(0, 3) == 0) begin
            i_miss_req = 0; i_wait = 1;
          end
        end else if (i_wait) begin
          if (s_idone) i_wait = 0;
        end else if ($urandom_range(0, 99) < p_raise) begin
          i_miss_req = 1; i_miss_addr = 16'($urandom);
        end
        if (d_miss_req) begin
          if (s_ddone) d_miss_req = 0;
        end else if ($urandom_range(0, 99) < p_raise) begin
          d_miss_req = 1; d_miss_addr = 16'($urandom);
        end
        if (d_wr_req) begin
          if (s_ack) d_wr_req = 0;
        end else if ($urandom_range(0, 99) < p_wr) begin
          d_wr_req = 1; d_wr_addr = 16'($urandom); d_wr_data = 16'($urandom);
        end
      end
    end
  endtask

  initial begin
    rst = 1;
    tick();
    tick();
    neg();
    chk("rst_busy", {15'b0, busy}, 16'd0);
    chk("rst_mem_en", {15'b0, mem_en}, 16'd0);
    rst = 0;
    repeat (6) tick();

    // I miss at 0x1234 alone
    tick(); i_miss_req = 1; i_miss_addr = 16'h1234;
    for (int k = 1; k <= 13; k++) begin
      tick();
      if (k == 13) i_miss_req = 0;
      neg();
      if (k == 1) chk("t1_first_addr", mem_addr, 16'h1230);
      if (k == 8) chk("t1_last_addr", mem_addr, 16'h123E);
      if (k <= 8) chk("t1_addr", mem_addr, 16'h1230 + 16'(2 * (k - 1)));
      if (k >= 5 && k <= 12) begin
        chk("t1_ivld", {15'b0, i_fill_valid}, 16'd1);
        chk("t1_word", {13'b0, fill_word}, 16'(k - 5));
      end
      chk("t1_done", {15'b0, i_fill_done}, (k == 12) ? 16'd1 : 16'd0);
    end

    // Same-cycle D miss 0x8000 and I miss 0x0040
    tick(); d_miss_req = 1; d_miss_addr = 16'h8000; i_miss_req = 1; i_miss_addr = 16'h0040;
    for (int k = 1; k <= 26; k++) begin
      tick();
      if (k == 13) d_miss_req = 0;
      if (k == 26) i_miss_req = 0;
      neg();
      if (k == 1) chk("t2_d_first", mem_addr, 16'h8000);
      if (k == 8) chk("t2_d_last", mem_addr, 16'h800E);
      if (k == 12) chk("t2_d_done", {15'b0, d_fill_done}, 16'd1);
      if (k == 13) chk("t2_gap", {15'b0, mem_en}, 16'd0);
      if (k == 14) begin
        chk("t2_i_en", {15'b0, mem_en}, 16'd1);
        chk("t2_i_first", mem_addr, 16'h0040);
      end
      if (k == 25) chk("t2_i_done", {15'b0, i_fill_done}, 16'd1);
    end

    // Write-through raised during an I fill
    tick(); i_miss_req = 1; i_miss_addr = 16'h2000;
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (k == 3) begin d_wr_req = 1; d_wr_addr = 16'h00A3; d_wr_data = 16'hBEEF; end
      if (k == 13) i_miss_req = 0;
      if (k == 15) d_wr_req = 0;
      neg();
      chk("t3_ack", {15'b0, d_wr_ack}, (k == 14) ? 16'd1 : 16'd0);
      if (k == 13) chk("t3_idle_en", {15'b0, mem_en}, 16'd0);
      if (k == 14) begin
        chk("t3_wr", {15'b0, mem_wr}, 16'd1);
        chk("t3_waddr", mem_addr, 16'h00A2);
        chk("t3_wdata", mem_wdata, 16'hBEEF);
      end
    end

    // Reset during the 5th fill cycle, then a clean I fill
    tick(); i_miss_req = 1; i_miss_addr = 16'h3000;
    for (int k = 1; k <= 23; k++) begin
      tick();
      if (k == 5) begin rst = 1; i_miss_req = 0; end
      if (k == 6) begin rst = 0; i_miss_req = 1; i_miss_addr = 16'h4000; end
      if (k == 23) i_miss_req = 0;
      neg();
      if (k == 6) begin
        chk("t4_busy0", {15'b0, busy}, 16'd0);
        chk("t4_data0", fill_data, 16'd0);
      end
      if (k >= 6 && k <= 10) begin
        chk("t4_no_grant", {15'b0, mem_en}, 16'd0);
        chk("t4_no_stale", {15'b0, i_fill_valid}, 16'd0);
      end
      if (k == 11) chk("t4_regrant", mem_addr, 16'h4000);
      if (k == 22) chk("t4_done", {15'b0, i_fill_done}, 16'd1);
    end

    // I request dropped at fill cycle 2
    tick(); i_miss_req = 1; i_miss_addr = 16'h5000;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (k == 2) i_miss_req = 0;
      neg();
      if (k == 12) chk("t5_done", {15'b0, i_fill_done}, 16'd1);
      if (k >= 13) chk("t5_no_refill", {15'b0, mem_en}, 16'd0);
    end

    run_random(2500, 30, 15);
    run_random(300, 100, 0);
    run_random(300, 60, 20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
